// File: rtl/alu_entry_seq_if.sv
// alu_entry_seq_if: switch/button inputs and result outputs of the
// operand-entry sequencer, bundled for the display-side connection.
interface alu_entry_seq_if;
    logic [5:0] sw_in;
    logic [1:0] op_sel;
    logic       enter_btn;
    logic       clear_btn;
    logic [5:0] result;
    logic       neg;
    logic       ovf;
    logic       valid;
    logic [1:0] state_led;

    modport master (
        output sw_in, op_sel, enter_btn, clear_btn,
        input  result, neg, ovf, valid, state_led
    );

    modport slave (
        input  sw_in, op_sel, enter_btn, clear_btn,
        output result, neg, ovf, valid, state_led
    );
endinterface

// File: rtl/alu_entry_seq.sv
// alu_entry_seq: two-operand entry FSM with a 6-bit signed ALU.
// Button debounce is compiled in by defining ALU_DEBOUNCE_EN.
module alu_entry_seq #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_entry_seq_if.slave bus
);
    localparam logic [1:0] S_LOAD_A = 2'b00;
    localparam logic [1:0] S_LOAD_B = 2'b01;
    localparam logic [1:0] S_SHOW   = 2'b10;

    if (DEBOUNCE_CYCLES < 1) begin : g_param_chk
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [5:0] sw_s1, sw_s2;
    logic [1:0] op_s1, op_s2;
    logic [1:0] btn_s1, btn_s2;
    logic [1:0] btn_lvl, btn_prev, press;
    logic       enter_p, clear_p;

    logic [1:0] state_q, state_d;
    logic [5:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic       ovf_q, ovf_d;
    logic [5:0] alu_res, sum, diff;
    logic       alu_ovf;

    // Two-flop synchronizers; bit 0 is enter, bit 1 is clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            op_s1  <= '0;
            op_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= bus.sw_in;
            sw_s2  <= sw_s1;
            op_s1  <= bus.op_sel;
            op_s2  <= op_s1;
            btn_s1 <= {bus.clear_btn, bus.enter_btn};
            btn_s2 <= btn_s1;
        end
    end

`ifdef ALU_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0][CW-1:0] db_cnt;
    logic [1:0]         db_lvl;

    // Accept a new level only after it persists for DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            db_lvl <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    db_lvl[i] <= btn_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_lvl = db_lvl;
`else
    assign btn_lvl = btn_s2;
`endif

    // Registered one-cycle press pulse on each rising accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= '0;
            press    <= '0;
        end else begin
            btn_prev <= btn_lvl;
            press    <= btn_lvl & ~btn_prev;
        end
    end

    assign enter_p = press[0];
    assign clear_p = press[1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; clear overrides a same-cycle enter.
    always_comb begin
        state_d = state_q;
        if (clear_p) begin
            state_d = S_LOAD_A;
        end else begin
            case (state_q)
                S_LOAD_A: if (enter_p) state_d = S_LOAD_B;
                S_LOAD_B: if (enter_p) state_d = S_SHOW;
                S_SHOW:   if (enter_p) state_d = S_LOAD_B;
                default:  state_d = S_LOAD_A;
            endcase
        end
    end

    // FSM outputs derived from the state register only.
    always_comb begin
        bus.valid     = (state_q == S_SHOW);
        bus.state_led = state_q;
    end

    // B operand captures the switches on the computing press.
    always_comb begin
        b_d = b_q;
        if (clear_p || state_q == 2'b11) begin
            b_d = '0;
        end else if (state_q == S_LOAD_B && enter_p) begin
            b_d = sw_s2;
        end
    end

    // Six-bit modulo arithmetic with signed overflow flag.
    always_comb begin
        sum     = a_q + b_d;
        diff    = a_q - b_d;
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (1'b1)
            op_s2 == 2'b00: begin
                alu_res = sum;
                alu_ovf = (a_q[5] == b_d[5]) && (sum[5] != a_q[5]);
            end
            op_s2 == 2'b01: begin
                alu_res = diff;
                alu_ovf = (a_q[5] != b_d[5]) && (diff[5] != a_q[5]);
            end
            op_s2 == 2'b10: alu_res = a_q & b_d;
            op_s2 == 2'b11: alu_res = a_q | b_d;
        endcase
    end

    // Operand A, result and overflow next values per state.
    always_comb begin
        a_d   = a_q;
        res_d = res_q;
        ovf_d = ovf_q;
        if (clear_p) begin
            a_d   = '0;
            res_d = '0;
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    res_d = sw_s2;
                    if (enter_p) a_d = sw_s2;
                end
                S_LOAD_B: begin
                    res_d = sw_s2;
                    if (enter_p) begin
                        res_d = alu_res;
                        ovf_d = alu_ovf;
                    end
                end
                S_SHOW: begin
                    if (enter_p) a_d = res_q;
                end
                default: begin
                    a_d   = '0;
                    res_d = '0;
                    ovf_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.result = res_q;
    assign bus.neg    = res_q[5];
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_alu_entry_seq.sv
// tb_alu_entry_seq: directed and random operand entry against
// an integer-arithmetic model of the calculator.
`timescale 1ns/1ps
module tb_alu_entry_seq;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_entry_seq_if bus();

    alu_entry_seq #(.DEBOUNCE_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef ALU_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int HOLD = DB + 4;

    int n_assert = 0;
    int n_fail   = 0;

    int m_state;
    int m_a, m_b, m_res, m_sw, m_op;
    int m_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_result"}, int'(bus.result), m_res);
        chk({tag, "_neg"}, int'(bus.neg), (m_res >= 32) ? 1 : 0);
        chk({tag, "_ovf"}, int'(bus.ovf), m_ovf);
        chk({tag, "_valid"}, int'(bus.valid), (m_state == 2) ? 1 : 0);
        chk({tag, "_state"}, int'(bus.state_led), m_state);
    endtask

    function automatic int signed6(input int v);
        return (v >= 32) ? v - 64 : v;
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_a     = 0;
        m_b     = 0;
        m_res   = 0;
        m_ovf   = 0;
    endfunction

    function automatic void model_enter();
        int r;
        case (m_state)
            0: begin
                m_a     = m_sw;
                m_state = 1;
            end
            1: begin
                m_b = m_sw;
                case (m_op)
                    0: r = signed6(m_a) + signed6(m_b);
                    1: r = signed6(m_a) - signed6(m_b);
                    2: r = m_a & m_b;
                    default: r = m_a | m_b;
                endcase
                m_ovf   = (m_op < 2 && (r > 31 || r < -32)) ? 1 : 0;
                m_res   = r & 63;
                m_state = 2;
            end
            default: begin
                m_a     = m_res;
                m_state = 1;
            end
        endcase
    endfunction

    task automatic set_sw(input int v);
        bus.sw_in = 6'(v);
        repeat (3) tick();
        m_sw = v;
        if (m_state != 2) m_res = v;
    endtask

    task automatic set_op(input int v);
        bus.op_sel = 2'(v);
        m_op = v;
    endtask

    task automatic press(input bit e, input bit c, input string tag);
        bus.enter_btn = e;
        bus.clear_btn = c;
        repeat (HOLD - 1) tick();
        chk({tag, "_early"}, int'(bus.state_led), m_state);
        tick();
        if (c) begin
            model_reset();
        end else if (e) begin
            model_enter();
        end
        check_all(tag);
        bus.enter_btn = 1'b0;
        bus.clear_btn = 1'b0;
        repeat (HOLD) tick();
        if (m_state != 2) m_res = m_sw;
        check_all({tag, "_rel"});
    endtask

    task automatic do_op(input int a, input int b, input int op, input string tag);
        if (m_state != 0) press(1'b0, 1'b1, {tag, "_clr"});
        set_sw(a);
        press(1'b1, 1'b0, {tag, "_a"});
        set_op(op);
        set_sw(b);
        press(1'b1, 1'b0, {tag, "_b"});
    endtask

    initial begin
        bus.sw_in     = '0;
        bus.op_sel    = '0;
        bus.enter_btn = 1'b0;
        bus.clear_btn = 1'b0;
        m_sw = 0;
        m_op = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_all("reset");
        rst_n = 1'b1;
        tick();

        // switch latency: three edges to the result
        bus.sw_in = 6'd5;
        repeat (2) tick();
        chk("sw_lat2", int'(bus.result), 0);
        tick();
        chk("sw_lat3", int'(bus.result), 5);
        m_sw  = 5;
        m_res = 5;

        // 5 + 3
        press(1'b1, 1'b0, "add_a");
        set_op(0);
        set_sw(3);
        press(1'b1, 1'b0, "add_b");

        // chain: 8 AND 2
        press(1'b1, 1'b0, "chain");
        set_op(2);
        set_sw(2);
        press(1'b1, 1'b0, "and_b");

        // clear beats a simultaneous enter
        press(1'b1, 1'b1, "clr_ent");

        do_op(3, 5, 1, "sub_neg");
        do_op(31, 1, 0, "add_ovf");
        do_op(32, 1, 1, "sub_ovf");

        // overflow held into LOAD_B after chaining
        press(1'b1, 1'b0, "ovf_hold");
        press(1'b0, 1'b1, "ovf_clr");

        // asynchronous reset while in LOAD_B with A=7
        set_sw(7);
        press(1'b1, 1'b0, "pre_rst");
        set_sw(4);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        m_res = m_sw;
        check_all("rst_rel");
        press(1'b1, 1'b0, "post_rst_a");
        set_op(0);
        set_sw(9);
        press(1'b1, 1'b0, "post_rst_b");

`ifdef ALU_DEBOUNCE_EN
        // short glitch is filtered out
        bus.enter_btn = 1'b1;
        repeat (10) tick();
        bus.enter_btn = 1'b0;
        repeat (HOLD) tick();
        check_all("glitch");
        // long hold yields a single press
        bus.enter_btn = 1'b1;
        repeat (HOLD + 12) tick();
        bus.enter_btn = 1'b0;
        model_enter();
        repeat (HOLD) tick();
        m_res = m_sw;
        check_all("long_hold");
`endif

        for (int i = 0; i < 25; i++) begin
            int a, b, op;
            a  = int'($urandom_range(0, 63));
            b  = int'($urandom_range(0, 63));
            op = int'($urandom_range(0, 3));
            if (m_state == 2 && $urandom_range(0, 3) == 0) begin
                press(1'b1, 1'b0, "rnd_chain");
                set_op(op);
                set_sw(b);
                press(1'b1, 1'b0, "rnd_chain_b");
            end else begin
                do_op(a, b, op, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
